prach_nco_sched: RTL and testbench



---
 rtl/prach_nco_sched.sv | 210 +++++++++++++++++++++
 tb/tb_prach_nco_sched.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prach_nco_sched.sv
// prach_nco_sched: slot scheduler and double-buffered configuration controller
// for the 8-channel interleaved PRACH NCO. Each accepted frame tick starts a
// frame of NUM_CHN slot cycles, optionally preceded by one accumulator sync
// cycle. Shadow FCW/enable banks transfer to the active banks only on frame
// boundaries.
// Optional feature: define PRACH_NCO_SCHED_OVR_CNT_EN to build the 16-bit
// saturating overrun counter on ovr_cnt (otherwise ovr_cnt is tied to 0).
module prach_nco_sched #(
    parameter int NUM_CHN = 8,
    parameter int CHN_W   = 3,
    parameter int FCW_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_tick,
    input  logic                     sync_req,
    input  logic                     cfg_wr,
    input  logic [CHN_W-1:0]         cfg_chn,
    input  logic [FCW_W-1:0]         cfg_fcw,
    input  logic                     cfg_en,
    input  logic                     cfg_commit,
    input  logic                     err_clr,
    output logic                     dout_dv,
    output logic [7:0]               dout_chn,
    output logic                     sync_out,
    output logic [NUM_CHN*FCW_W-1:0] fcw_active,
    output logic                     cfg_pending,
    output logic                     cfg_done,
    output logic                     busy,
    output logic                     err_overrun,
    output logic [15:0]              ovr_cnt
);

    typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

    localparam logic [CHN_W-1:0] LAST_SLOT = CHN_W'(NUM_CHN - 1);

    state_t                     state_q, state_d;
    logic [CHN_W-1:0]           slot_q, slot_d;
    logic                       sync_pend_q, sync_pend_d;
    logic                       cfg_pending_q, cfg_pending_d;
    logic [NUM_CHN*FCW_W-1:0]   shadow_fcw_q, shadow_fcw_d;
    logic [NUM_CHN-1:0]         shadow_en_q, shadow_en_d;
    logic [NUM_CHN*FCW_W-1:0]   active_fcw_q, active_fcw_d;
    logic [NUM_CHN-1:0]         active_en_q, active_en_d;
    logic                       dout_dv_q, dout_dv_d;
    logic [7:0]                 dout_chn_q, dout_chn_d;
    logic                       sync_out_q, sync_out_d;
    logic                       cfg_done_q, cfg_done_d;
    logic                       busy_q, busy_d;
    logic                       err_overrun_q, err_overrun_d;

    logic last_slot;
    logic accept;
    logic overrun;

    assign last_slot = (state_q == RUN) && (slot_q == LAST_SLOT);
    assign accept    = frame_tick && ((state_q == IDLE) || last_slot);
    assign overrun   = frame_tick && !accept;

    // Next-state, bank updates and registered-output values for the coming cycle.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        slot_d        = slot_q;
        sync_pend_d   = sync_pend_q;
        cfg_pending_d = cfg_pending_q;
        shadow_fcw_d  = shadow_fcw_q;
        shadow_en_d   = shadow_en_q;
        active_fcw_d  = active_fcw_q;
        active_en_d   = active_en_q;
        dout_dv_d     = 1'b0;
        dout_chn_d    = 8'd0;
        sync_out_d    = 1'b0;
        cfg_done_d    = 1'b0;
        busy_d        = 1'b0;
        err_overrun_d = err_overrun_q;

        // Active bank copies the pre-write shadow, so a same-cycle cfg_wr waits
        // for the next commit.
        if (accept && (cfg_pending_q || cfg_commit)) begin
            active_fcw_d  = shadow_fcw_q;
            active_en_d   = shadow_en_q;
            cfg_pending_d = 1'b0;
            cfg_done_d    = 1'b1;
        end else if (cfg_commit) begin
            cfg_pending_d = 1'b1;
        end

        if (cfg_wr) begin
            shadow_fcw_d[cfg_chn*FCW_W +: FCW_W] = cfg_fcw;
            shadow_en_d[cfg_chn]                 = cfg_en;
        end

        if (accept) begin
            sync_pend_d = 1'b0;
            slot_d      = '0;
            state_d     = (sync_pend_q || sync_req) ? SYNC : RUN;
        end else begin
            if (sync_req) begin
                sync_pend_d = 1'b1;
            end
            case (state_q)
                SYNC: begin
                    state_d = RUN;
                    slot_d  = '0;
                end
                RUN: begin
                    if (last_slot) begin
                        state_d = IDLE;
                        slot_d  = '0;
                    end else begin
                        slot_d = slot_q + CHN_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        sync_out_d = (state_d == SYNC);
        busy_d     = (state_d != IDLE);
        if (state_d == RUN) begin
            dout_dv_d  = active_en_d[slot_d];
            dout_chn_d = 8'(slot_d);
        end

        if (err_clr) begin
            err_overrun_d = 1'b0;
        end else if (overrun) begin
            err_overrun_d = 1'b1;
        end
    end

    // State, banks and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: the configuration banks are reset along with the control state
        // because channels must come up disabled with zero FCWs.
        if (rst) begin
            state_q       <= IDLE;
            slot_q        <= '0;
            sync_pend_q   <= 1'b0;
            cfg_pending_q <= 1'b0;
            shadow_fcw_q  <= '0;
            shadow_en_q   <= '0;
            active_fcw_q  <= '0;
            active_en_q   <= '0;
            dout_dv_q     <= 1'b0;
            dout_chn_q    <= 8'd0;
            sync_out_q    <= 1'b0;
            cfg_done_q    <= 1'b0;
            busy_q        <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values regardless of statement order.
            state_q       <= state_d;
            slot_q        <= slot_d;
            sync_pend_q   <= sync_pend_d;
            cfg_pending_q <= cfg_pending_d;
            shadow_fcw_q  <= shadow_fcw_d;
            shadow_en_q   <= shadow_en_d;
            active_fcw_q  <= active_fcw_d;
            active_en_q   <= active_en_d;
            dout_dv_q     <= dout_dv_d;
            dout_chn_q    <= dout_chn_d;
            sync_out_q    <= sync_out_d;
            cfg_done_q    <= cfg_done_d;
            busy_q        <= busy_d;
            err_overrun_q <= err_overrun_d;
        end
    end

`ifdef PRACH_NCO_SCHED_OVR_CNT_EN
    logic [15:0] ovr_cnt_q, ovr_cnt_d;

    // Saturating count of dropped ticks; a clear beats a simultaneous overrun.
    always_comb begin
        ovr_cnt_d = ovr_cnt_q;
        if (err_clr) begin
            ovr_cnt_d = 16'd0;
        end else if (overrun && (ovr_cnt_q != 16'hFFFF)) begin
            ovr_cnt_d = ovr_cnt_q + 16'd1;
        end
    end

    // Overrun counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_cnt_q <= 16'd0;
        end else begin
            ovr_cnt_q <= ovr_cnt_d;
        end
    end

    assign ovr_cnt = ovr_cnt_q;
`else
    assign ovr_cnt = 16'd0;
`endif

    assign dout_dv     = dout_dv_q;
    assign dout_chn    = dout_chn_q;
    assign sync_out    = sync_out_q;
    assign fcw_active  = active_fcw_q;
    assign cfg_pending = cfg_pending_q;
    assign cfg_done    = cfg_done_q;
    assign busy        = busy_q;
    assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_prach_nco_sched.sv
// Directed self-checking bench for prach_nco_sched (NUM_CHN=8, FCW_W=16).
module tb_prach_nco_sched;

    localparam int NUM_CHN = 8;
    localparam int CHN_W   = 3;
    localparam int FCW_W   = 16;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     frame_tick;
    logic                     sync_req;
    logic                     cfg_wr;
    logic [CHN_W-1:0]         cfg_chn;
    logic [FCW_W-1:0]         cfg_fcw;
    logic                     cfg_en;
    logic                     cfg_commit;
    logic                     err_clr;
    logic                     dout_dv;
    logic [7:0]               dout_chn;
    logic                     sync_out;
    logic [NUM_CHN*FCW_W-1:0] fcw_active;
    logic                     cfg_pending;
    logic                     cfg_done;
    logic                     busy;
    logic                     err_overrun;
    logic [15:0]              ovr_cnt;

    int n_checks = 0;
    int n_errors = 0;
    logic [NUM_CHN*FCW_W-1:0] exp_fcw;
    logic [15:0]              exp_ovr1;

    prach_nco_sched #(.NUM_CHN(NUM_CHN), .CHN_W(CHN_W), .FCW_W(FCW_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .sync_req    (sync_req),
        .cfg_wr      (cfg_wr),
        .cfg_chn     (cfg_chn),
        .cfg_fcw     (cfg_fcw),
        .cfg_en      (cfg_en),
        .cfg_commit  (cfg_commit),
        .err_clr     (err_clr),
        .dout_dv     (dout_dv),
        .dout_chn    (dout_chn),
        .sync_out    (sync_out),
        .fcw_active  (fcw_active),
        .cfg_pending (cfg_pending),
        .cfg_done    (cfg_done),
        .busy        (busy),
        .err_overrun (err_overrun),
        .ovr_cnt     (ovr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs set before the call are sampled at this edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " dv"},      128'(dout_dv),     128'd0);
        check({tag, " chn"},     128'(dout_chn),    128'd0);
        check({tag, " sync"},    128'(sync_out),    128'd0);
        check({tag, " fcw"},     128'(fcw_active),  128'd0);
        check({tag, " pend"},    128'(cfg_pending), 128'd0);
        check({tag, " done"},    128'(cfg_done),    128'd0);
        check({tag, " busy"},    128'(busy),        128'd0);
        check({tag, " err"},     128'(err_overrun), 128'd0);
        check({tag, " ovr_cnt"}, 128'(ovr_cnt),     128'd0);
    endtask

    // Tick now, then check one whole frame; returns while slot NUM_CHN-1 is visible.
    task automatic frame(input string tag, input logic [7:0] mask, input bit sync_exp);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        cfg_wr     = 1'b0;
        cfg_commit = 1'b0;
        sync_req   = 1'b0;
        check({tag, " fcw@T+1"}, 128'(fcw_active), 128'(exp_fcw));
        if (sync_exp) begin
            check({tag, " sync_out"}, 128'(sync_out), 128'd1);
            check({tag, " sync dv"},  128'(dout_dv),  128'd0);
            step();
        end
        for (int k = 0; k < NUM_CHN; k++) begin
            check($sformatf("%s slot%0d sync", tag, k), 128'(sync_out), 128'd0);
            check($sformatf("%s slot%0d dv", tag, k),   128'(dout_dv),  128'(mask[k]));
            check($sformatf("%s slot%0d chn", tag, k),  128'(dout_chn), 128'(k));
            check($sformatf("%s slot%0d busy", tag, k), 128'(busy),     128'd1);
            if (k < NUM_CHN - 1) step();
        end
    endtask

    initial begin
        logic [7:0] mask;
`ifdef PRACH_NCO_SCHED_OVR_CNT_EN
        exp_ovr1 = 16'd1;
`else
        exp_ovr1 = 16'd0;
`endif
        rst = 1'b1; frame_tick = 1'b0; sync_req = 1'b0; cfg_wr = 1'b0;
        cfg_chn = '0; cfg_fcw = '0; cfg_en = 1'b0; cfg_commit = 1'b0; err_clr = 1'b0;
        exp_fcw = '0;
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;
        step();

        // All channels enabled with distinct FCWs.
        for (int i = 0; i < NUM_CHN; i++) begin
            cfg_wr = 1'b1; cfg_chn = CHN_W'(i); cfg_fcw = 16'h1000 + 16'(i); cfg_en = 1'b1;
            exp_fcw[i*FCW_W +: FCW_W] = 16'h1000 + 16'(i);
            step();
        end
        cfg_wr = 1'b0;
        check("shadow not active", 128'(fcw_active), 128'd0);
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
        check("pending after commit", 128'(cfg_pending), 128'd1);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check("cfg_done T+1", 128'(cfg_done), 128'd1);
        check("pending cleared", 128'(cfg_pending), 128'd0);
        check("fcw applied", 128'(fcw_active), 128'(exp_fcw));
        check("first slot dv", 128'(dout_dv), 128'd1);
        check("first slot chn", 128'(dout_chn), 128'd0);
        for (int k = 1; k < NUM_CHN; k++) begin
            step();
            check($sformatf("all-en slot%0d dv", k), 128'(dout_dv), 128'd1);
            check($sformatf("all-en slot%0d chn", k), 128'(dout_chn), 128'(k));
        end
        check("cfg_done one pulse", 128'(cfg_done), 128'd0);
        step();
        check("idle busy", 128'(busy), 128'd0);
        check("idle dv", 128'(dout_dv), 128'd0);

        // Sparse enable mask 0xA5.
        mask = 8'hA5;
        for (int i = 0; i < NUM_CHN; i++) begin
            cfg_wr = 1'b1; cfg_chn = CHN_W'(i); cfg_fcw = 16'h1000 + 16'(i); cfg_en = mask[i];
            step();
        end
        cfg_wr = 1'b0;
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
        frame("mask A5", 8'hA5, 1'b0);
        step();
        check("A5 idle busy", 128'(busy), 128'd0);

        // Sync request waits for the next tick, then fires once.
        sync_req = 1'b1;
        step();
        sync_req = 1'b0;
        step();
        step();
        check("sync not early", 128'(sync_out), 128'd0);
        frame("sync frame", 8'hA5, 1'b1);
        step();
        frame("post-sync frame", 8'hA5, 1'b0);
        step();

        // Overrun: tick at slot 3 is dropped; clear wins over simultaneous overrun.
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step(); step(); step();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check("ovr slot kept", 128'(dout_chn), 128'd4);
        check("err_overrun set", 128'(err_overrun), 128'd1);
        check("ovr_cnt one", 128'(ovr_cnt), 128'(exp_ovr1));
        err_clr = 1'b1;
        step();
        check("err cleared", 128'(err_overrun), 128'd0);
        check("ovr_cnt cleared", 128'(ovr_cnt), 128'd0);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        err_clr = 1'b0;
        check("clr beats overrun err", 128'(err_overrun), 128'd0);
        check("clr beats overrun cnt", 128'(ovr_cnt), 128'd0);
        step();
        check("at last slot", 128'(dout_chn), 128'd7);
        frame("back-to-back", 8'hA5, 1'b0);
        check("b2b no overrun", 128'(err_overrun), 128'd0);
        step();

        // Shadow write in the same cycle as the applying tick stays shadowed.
        cfg_wr = 1'b1; cfg_chn = 3'd3; cfg_fcw = 16'h1234; cfg_en = 1'b1;
        step();
        cfg_wr = 1'b0;
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
        cfg_wr = 1'b1; cfg_chn = 3'd3; cfg_fcw = 16'h5678; cfg_en = 1'b1;
        exp_fcw[3*FCW_W +: FCW_W] = 16'h1234;
        frame("commit 1234", 8'hAD, 1'b0);
        check("chn3 1234", 128'(fcw_active[3*FCW_W +: FCW_W]), 128'h1234);
        step();
        cfg_commit = 1'b1;
        exp_fcw[3*FCW_W +: FCW_W] = 16'h5678;
        frame("commit 5678", 8'hAD, 1'b0);
        check("chn3 5678", 128'(fcw_active[3*FCW_W +: FCW_W]), 128'h5678);
        step();

        // Reset in mid-frame aborts it; next frame restarts with all channels off.
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step(); step(); step(); step();
        check("at slot 4", 128'(dout_chn), 128'd4);
        rst = 1'b1;
        step();
        check_all_zero("mid-frame reset");
        rst = 1'b0;
        exp_fcw = '0;
        step();
        frame("after reset", 8'h00, 1'b0);
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
